// File: rtl/float16_pkg.sv
// Shared definitions for the 16-bit float format {sign, exp[7:0], mant[6:0]}.
// Used by the squarer top, its interface and the bench.
package float16_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 7;
    localparam int BIAS   = 127;

    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } float16_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/floating_point_square_if.sv
// Start/result handshake bundle for floating_point_square.
// The master side issues operands; the slave side is the squarer.
interface floating_point_square_if;
    import float16_pkg::*;

    logic     square_start;
    float16_t num_i;
    float16_t num_o;
    logic     valid_o;
    logic     error_o;
    logic     busy_o;

    modport master (
        output square_start, num_i,
        input  num_o, valid_o, error_o, busy_o
    );

    modport slave (
        input  square_start, num_i,
        output num_o, valid_o, error_o, busy_o
    );

endinterface

// File: rtl/seq_shift_add_mult.sv
// Iterative unsigned W x W multiplier: one partial product per cycle after load.
// 'last' is high during the cycle whose closing edge adds the final partial product.
module seq_shift_add_mult #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] product,
    output logic           last
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [2*W-1:0] mcand;
    logic [2*W-1:0] acc;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  cnt;
    logic           run;

    assign last    = run && (cnt == CW'(W - 1));
    assign product = acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            run    <= 1'b0;
        end else if (load) begin
            mcand  <= {{W{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            run    <= 1'b1;
        end else if (run) begin
            // multiplier is consumed LSB first while the multiplicand walks left
            if (mplier[0])
                acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (last)
                run <= 1'b0;
        end
    end

endmodule

// File: rtl/floating_point_square.sv
// Sequential x^2 unit for the 16-bit float format: shift-add mantissa product, then
// one normalise/pack cycle. Define FLOATING_SQUARE_ROUND_EN for round-to-nearest-even.
module floating_point_square
    import float16_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    floating_point_square_if.slave   sq
);

    localparam int MW = MANT_W + 1;
    localparam int PW = 2 * MW;
    localparam int EW = EXP_W + 2;

    state_t          state, state_nx;
    float16_t        opnd;
    float16_t        num_q;
    logic            err_q, valid_q, busy_q;
    logic [PW-1:0]   prod;
    logic            mult_last;
    logic            load;

    logic                 n;
    logic [PW-1:0]        pn;
    logic [MANT_W-1:0]    mant_k, mant_r;
    logic signed [EW-1:0] e_res, e_rnd;
    float16_t             res_num;
    logic                 res_err;

    assign load = (state == IDLE) && sq.square_start;

    seq_shift_add_mult #(.W(MW)) u_mult (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .a       ({1'b1, sq.num_i.mant}),
        .b       ({1'b1, sq.num_i.mant}),
        .product (prod),
        .last    (mult_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sq.square_start) state_nx = MULT;
            MULT:    if (mult_last)       state_nx = NORM;
            NORM:    state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Normalise: the product of two [1,2) mantissas lies in [1,4), so at most one shift.
    always_comb begin
        n      = prod[PW-1];
        pn     = n ? prod : (prod << 1);
        mant_k = pn[PW-2 -: MANT_W];
        e_res  = $signed({1'b0, opnd.exp, 1'b0}) - $signed(EW'(BIAS))
               + $signed({{(EW-1){1'b0}}, n});
    end

`ifdef FLOATING_SQUARE_ROUND_EN
    logic           guard, sticky, rnd_inc;
    logic [MANT_W:0] mant_sum;

    always_comb begin
        guard    = pn[MANT_W];
        sticky   = |pn[MANT_W-1:0];
        rnd_inc  = guard & (sticky | mant_k[0]);
        mant_sum = {1'b0, mant_k} + {{MANT_W{1'b0}}, rnd_inc};
        mant_r   = mant_sum[MANT_W-1:0];
        e_rnd    = e_res + $signed({{(EW-1){1'b0}}, mant_sum[MANT_W]});
    end
`else
    logic unused_low;
    assign unused_low = ^pn[MANT_W:0];

    always_comb begin
        mant_r = mant_k;
        e_rnd  = e_res;
    end
`endif

    logic unused_sign;
    assign unused_sign = opnd.sign;

    always_comb begin
        res_num = '0;
        res_err = 1'b0;
        if (opnd.exp == '0) begin
            res_num = '0;
        end else if (opnd.exp == EXP_MAX) begin
            res_num.exp = EXP_MAX;
            res_err     = 1'b1;
        end else if (e_rnd >= $signed({2'b00, EXP_MAX})) begin
            res_num.exp = EXP_MAX;
            res_err     = 1'b1;
        end else if (!e_rnd[EW-1] && (e_rnd != '0)) begin
            res_num.exp  = e_rnd[EXP_W-1:0];
            res_num.mant = mant_r;
        end
    end

    // valid/busy are registered, so the pulse lands in the cycle after DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opnd    <= '0;
            num_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= (state == DONE);
            busy_q  <= (state_nx != IDLE) || (state == DONE);
            if (load)
                opnd <= sq.num_i;
            if (state == NORM) begin
                num_q <= res_num;
                err_q <= res_err;
            end
        end
    end

    assign sq.num_o   = num_q;
    assign sq.error_o = err_q;
    assign sq.valid_o = valid_q;
    assign sq.busy_o  = busy_q;

endmodule

// File: doc/floating_point_square.md
Name: floating_point_square

Overview:
- Sequential squarer for the team's 16-bit float format: sign[15], exponent[14:7] (bias 127), mantissa[6:0] with hidden 1.
- Inverse operation of the square-root datapath; used to check/re-expand sqrt results and as a stand-alone x^2 unit.
- Mantissa product uses an iterative shift-add multiplier (one partial product per cycle), then a single normalise/pack cycle.
- Start/valid/error handshake.

Parameters:
- EXP_W, 8, exponent field width
- MANT_W, 7, stored mantissa width (hidden bit excluded)
- BIAS, 127, exponent bias

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- square_start  input  1  request; sampled only in IDLE
- num_i  input  1+EXP_W+MANT_W  operand {sign, exp, mant}
- num_o  output  1+EXP_W+MANT_W  result; registered, held until next result
- valid_o  output  1  one-cycle pulse, result on num_o
- error_o  output  1  qualifies valid_o: overflow, Inf or NaN input
- busy_o  output  1  high from the cycle after start acceptance until the valid_o cycle inclusive

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE; num_o=0; valid_o=0; error_o=0; busy_o=0; counter and accumulator cleared. The operation in flight is discarded and produces no valid_o.
- States:
  - IDLE: square_start=1 latches num_i; goes to MULT. square_start is ignored in all other states.
  - MULT: MANT_W+1 cycles. Multiplicand is {1,mant} of width MANT_W+1. Each cycle, if the current multiplier bit is 1, add the shifted multiplicand to a 2*(MANT_W+1)-bit accumulator. Counter runs 0..MANT_W; goes to NORM after the last iteration.
  - NORM: one cycle. Normalise, round, pack, and register num_o/error_o. Go to DONE.
  - DONE: valid_o=1 for this cycle only. Go to IDLE.
- Latency: if start is sampled at edge k, valid_o is high in the cycle following edge k+MANT_W+3 (edge k+10 for defaults). Latency is the same for every operand class. Throughput is one result per MANT_W+4 cycles.
- Arithmetic, with P the 16-bit product:
  - n = P[15].
  - If n=1: mant = P[14:8]. Else: mant = P[13:7].
  - Unbiased result exponent E = 2*e - BIAS + n, computed in EXP_W+2-bit signed.
  - Output sign is always 0.
- Special cases, decided from the latched operand:
  - e=0 (zero or denormal, flushed): num_o=0, error_o=0.
  - e=all-ones (Inf or NaN): num_o={0,all-ones,0}, error_o=1.
  - E >= 2^EXP_W - 1 (overflow): num_o={0,all-ones,0}, error_o=1.
  - E <= 0 (underflow): num_o=0, error_o=0.
- error_o changes only in NORM. It is meaningful only while valid_o=1; otherwise it holds its last value.

Optional Feature:
- FLOATING_SQUARE_ROUND_EN
- Without the macro: discarded product bits are truncated.
- With the macro: round-to-nearest-even.
  - Guard = the bit just below the kept mantissa; sticky = OR of all lower bits.
  - Increment the mantissa when guard=1 and (sticky=1 or mantissa LSB=1).
  - Mantissa carry-out sets mant=0 and E=E+1. The overflow check is applied after rounding.
- Rounding logic adds no cycles; latency is unchanged.

Decomposition:
- Shared package float16_pkg holds:
  - EXP_W, MANT_W, BIAS
  - typedef float16_t, a packed struct {sign, exp, mant}
  - EXP_MAX constant (all-ones exponent)
  - state enum {IDLE, MULT, NORM, DONE}
- One sub-module is natural: seq_shift_add_mult. It is a parameterised-width iterative unsigned multiplier with load/done, instanced for the (MANT_W+1)-bit product.
- The FSM, special-case detection and normalise/pack stay in the top module.

Test Plan:
- 0x3FC0 (1.5), start pulse → valid_o exactly 10 cycles later, num_o=0x4010 (2.25), error_o=0, busy_o high throughout.
- 0xC000 (-2.0) → num_o=0x4080 (4.0), error_o=0. 0x0000 → 0x0000, error_o=0.
- 0x7F00 → num_o=0x7F80, error_o=1 (overflow). 0x1F80 → 0x0000, error_o=0 (underflow). 0x7F80 (Inf) → 0x7F80, error_o=1.
- 0x3FB5 → 0x3FFF without the macro; 0x4000 with FLOATING_SQUARE_ROUND_EN (mantissa carry-out into exponent).
- Second square_start asserted while busy_o=1 is ignored: only one valid_o, with the first operand's result. Back-to-back starts issued on the cycle after DONE are both accepted.
- rst asserted asynchronously mid-MULT, held 1 cycle → outputs immediately 0, no valid_o. A new start then gives the correct result with full latency.
